// File: rtl/vmem_stream_out.sv
// ---------------------------------------------------------------------------
// vmem_stream_out
//
// Reads a block of 256-bit vector lines from the data memory's wide read port
// (port B) and serialises each line as 16-bit words on a valid/ready stream,
// least-significant slice first. A host/control pulse on 'start' launches a
// transfer. The block is independent of the SIMD processor.
//
// Optional feature (compile-time macro VMEM_STREAM_CHECKSUM_EN):
//   When defined, a 16-bit running sum (mod 2^16) of every emitted data word
//   is kept. It is cleared on start and sent as one extra stream word after
//   the final line. With the macro undefined there is no checksum state,
//   no extra word and no adder.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   reset      in   1       asynchronous, active-high reset
//   start      in   1       1-cycle pulse; latches base_addr/num_lines when idle
//   base_addr  in   ADDR_W  byte address of first line (low bits forced to 0)
//   num_lines  in   CNT_W   number of lines to transfer; 0 is legal
//   mem_addr   out  ADDR_W  port-B read address
//   mem_rdata  in   LINE_W  port-B read data, valid 1 cycle after mem_addr
//   out_data   out  OUT_W   stream word
//   out_valid  out  1       out_data valid
//   out_ready  in   1       sink accepts word when out_valid & out_ready
//   busy       out  1       high from accepted start until done
//   done       out  1       1-cycle pulse when transfer completes
// ---------------------------------------------------------------------------
module vmem_stream_out #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int OUT_W  = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_lines,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [LINE_W-1:0] mem_rdata,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   localparam int BEATS      = LINE_W / OUT_W;
   localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LINE_BYTES = LINE_W / 8;

   // Clears the byte-offset bits so every fetch is line aligned.
   localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_BYTES - 1));

`ifdef VMEM_STREAM_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_SEND,
      S_CSUM,
      S_FINISH
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_SEND,
      S_FINISH
   } state_t;
`endif

   state_t              state_q,     state_d;
   logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
   logic [CNT_W-1:0]    line_cnt_q,  line_cnt_d;
   logic [BEAT_W-1:0]   beat_q,      beat_d;
   logic [LINE_W-1:0]   shift_q,     shift_d;
   logic [OUT_W-1:0]    out_data_q,  out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q,      busy_d;
   logic                done_q,      done_d;
   logic                accept;
`ifdef VMEM_STREAM_CHECKSUM_EN
   logic [OUT_W-1:0]    sum_q,       sum_d;
`endif

   // A word leaves the block on every cycle where both sides agree.
   assign accept = out_valid_q & out_ready;

   // Next-state and next-output computation for the whole transfer sequence.
   // Every output is produced from a flop, so the stream side never sees
   // combinational paths from out_ready back to out_valid/out_data.
   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      line_cnt_d  = line_cnt_q;
      beat_d      = beat_q;
      shift_d     = shift_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
`ifdef VMEM_STREAM_CHECKSUM_EN
      sum_d       = sum_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mem_addr_d = base_addr & LINE_MASK;
               line_cnt_d = num_lines;
               busy_d     = 1'b1;
`ifdef VMEM_STREAM_CHECKSUM_EN
               sum_d      = '0;
`endif
               if (num_lines == '0) begin
`ifdef VMEM_STREAM_CHECKSUM_EN
                  // An empty transfer still reports its (zero) checksum.
                  state_d     = S_CSUM;
                  out_valid_d = 1'b1;
                  out_data_d  = '0;
`else
                  state_d = S_FINISH;
                  done_d  = 1'b1;
`endif
               end else begin
                  state_d = S_FETCH;
               end
            end
         end

         // Address is already on the port; this cycle covers memory latency.
         S_FETCH: begin
            state_d = S_WAIT;
         end

         S_WAIT: begin
            shift_d     = mem_rdata;
            beat_d      = BEAT_W'(BEATS - 1);
            out_valid_d = 1'b1;
            out_data_d  = mem_rdata[OUT_W-1:0];
            state_d     = S_SEND;
         end

         S_SEND: begin
            if (accept) begin
               shift_d = shift_q >> OUT_W;
`ifdef VMEM_STREAM_CHECKSUM_EN
               sum_d   = sum_q + out_data_q;
`endif
               if (beat_q != '0) begin
                  beat_d     = beat_q - BEAT_W'(1);
                  out_data_d = shift_d[OUT_W-1:0];
               end else begin
                  line_cnt_d = line_cnt_q - CNT_W'(1);
                  mem_addr_d = mem_addr_q + ADDR_W'(LINE_BYTES);
                  if (line_cnt_q != CNT_W'(1)) begin
                     state_d     = S_FETCH;
                     out_valid_d = 1'b0;
                  end else begin
`ifdef VMEM_STREAM_CHECKSUM_EN
                     // sum_d already includes the word just accepted.
                     state_d    = S_CSUM;
                     out_data_d = sum_d;
`else
                     state_d     = S_FINISH;
                     out_valid_d = 1'b0;
                     done_d      = 1'b1;
`endif
                  end
               end
            end
         end

`ifdef VMEM_STREAM_CHECKSUM_EN
         S_CSUM: begin
            if (accept) begin
               out_valid_d = 1'b0;
               state_d     = S_FINISH;
               done_d      = 1'b1;
            end
         end
`endif

         // done is high during this cycle; start is deliberately not sampled.
         S_FINISH: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register; reset aborts any transfer in flight without a done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         mem_addr_q  <= '0;
         line_cnt_q  <= '0;
         beat_q      <= '0;
         shift_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef VMEM_STREAM_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         line_cnt_q  <= line_cnt_d;
         beat_q      <= beat_d;
         shift_q     <= shift_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef VMEM_STREAM_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign mem_addr  = mem_addr_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_vmem_stream_out.sv
// ---------------------------------------------------------------------------
// tb_vmem_stream_out
//
// Directed bench for vmem_stream_out. A behavioural port-B memory returns a
// line whose 16-bit words are derived from the line address, so every word
// can be predicted independently. Honours VMEM_STREAM_CHECKSUM_EN when the
// same macro is defined for the build.
// ---------------------------------------------------------------------------
module tb_vmem_stream_out;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [31:0]   base_addr;
   logic [15:0]   num_lines;
   logic [31:0]   mem_addr;
   logic [255:0]  mem_rdata = '0;
   logic [15:0]   out_data;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          done;

   int            checks = 0;
   int            passes = 0;

   logic [15:0]   got_words[$];
   logic [31:0]   got_addrs[$];
   logic [15:0]   csum_word;
   int            extra_words;
   int            first_valid;
   int            last_data_acc;
   int            last_acc;
   int            done_cyc;
   int            hold_err;
   int            busy_at1;

`ifdef VMEM_STREAM_CHECKSUM_EN
   localparam int CSUM_ON = 1;
`else
   localparam int CSUM_ON = 0;
`endif

   vmem_stream_out dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .num_lines (num_lines),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Word i of the line at address a: line index (minus 2) in the upper
   // bits, word index in the low nibble. Address 0x40 gives words 0..15.
   function automatic logic [15:0] word_of(input logic [31:0] a, input int i);
      logic [15:0] hi;
      hi = a[20:5] - 16'd2;
      return (hi << 4) + 16'(i);
   endfunction

   function automatic logic [255:0] line_of(input logic [31:0] a);
      logic [255:0] l;
      l = '0;
      for (int i = 0; i < 16; i++) l[i*16 +: 16] = word_of(a, i);
      return l;
   endfunction

   // Port-B model: one cycle of read latency.
   always @(posedge clk) mem_rdata <= line_of(mem_addr);

   // One comparison; passes only advances when observed matches expected.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   // Pulses start for one cycle; called and returns at posedge+1.
   task automatic applyStimulus(input logic [31:0] b, input logic [15:0] n);
      start     = 1'b1;
      base_addr = b;
      num_lines = n;
      @(posedge clk); #1;
      start     = 1'b0;
   endtask

   // Observes a transfer cycle by cycle (cycle 1 = first cycle after start).
   // toggle: ready high only on even cycles. restart_cyc: cycle of a second
   // start pulse with a different base (or -1 for none).
   task automatic runTransfer(input int n, input int budget, input bit toggle,
                              input int restart_cyc);
      int       cyc;
      int       beat;
      logic     prev_stall;
      logic [15:0] prev_data;
      got_words.delete();
      got_addrs.delete();
      csum_word     = 16'hDEAD;
      extra_words   = 0;
      first_valid   = -1;
      last_data_acc = -1;
      last_acc      = -1;
      done_cyc      = -1;
      hold_err      = 0;
      busy_at1      = 0;
      cyc           = 1;
      beat          = 0;
      prev_stall    = 1'b0;
      prev_data     = '0;
      while (cyc < budget && done_cyc < 0) begin
         out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (cyc == restart_cyc) begin
            start     = 1'b1;
            base_addr = 32'h0000_0100;
            num_lines = 16'd5;
         end else begin
            start = 1'b0;
         end
         if (cyc == 1) busy_at1 = int'(busy);
         if (prev_stall && (!out_valid || out_data !== prev_data)) hold_err++;
         if (done) done_cyc = cyc;
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (out_valid && out_ready) begin
            if (beat < 16*n) begin
               if (beat % 16 == 0) got_addrs.push_back(mem_addr);
               got_words.push_back(out_data);
               last_data_acc = cyc;
            end else begin
               extra_words++;
               csum_word = out_data;
            end
            last_acc = cyc;
            beat++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         @(posedge clk); #1;
         cyc++;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      checkOutput("done_seen", 32'(done_cyc >= 0), 32'd1);
      checkOutput("done_width", 32'(done), 32'd0);
      checkOutput("busy_after_done", 32'(busy), 32'd0);
   endtask

   // Compares collected words/addresses against the address-derived model.
   task automatic checkWords(input logic [31:0] base, input int n);
      logic [15:0] exp_sum;
      logic [31:0] a;
      exp_sum = '0;
      checkOutput("word_count", 32'(got_words.size()), 32'(16*n));
      checkOutput("line_count", 32'(got_addrs.size()), 32'(n));
      for (int l = 0; l < n; l++) begin
         a = base + 32'(32*l);
         if (l < got_addrs.size()) checkOutput("line_addr", got_addrs[l], a);
         for (int i = 0; i < 16; i++) begin
            exp_sum = exp_sum + word_of(a, i);
            if (l*16 + i < got_words.size())
               checkOutput("word", 32'(got_words[l*16+i]), 32'(word_of(a, i)));
         end
      end
      checkOutput("extra_words", 32'(extra_words), 32'(CSUM_ON));
      if (CSUM_ON != 0) checkOutput("checksum", 32'(csum_word), 32'(exp_sum));
   endtask

   initial begin
      int done_hits;
      reset     = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      num_lines = '0;
      out_ready = 1'b1;

      // Power-on reset state.
      #2 reset = 1'b1;
      #1;
      checkOutput("rst_mem_addr",  mem_addr,          32'h0);
      checkOutput("rst_out_data",  32'(out_data),     32'h0);
      checkOutput("rst_out_valid", 32'(out_valid),    32'h0);
      checkOutput("rst_busy",      32'(busy),         32'h0);
      checkOutput("rst_done",      32'(done),         32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Test 1: reset while word 5 of line 0 is presented.
      applyStimulus(32'h0000_0040, 16'd2);
      repeat (7) begin @(posedge clk); #1; end
      checkOutput("t1_beat5_data",  32'(out_data),  32'h5);
      checkOutput("t1_beat5_valid", 32'(out_valid), 32'h1);
      reset = 1'b1;
      #1;
      checkOutput("t1_rst_valid", 32'(out_valid), 32'h0);
      checkOutput("t1_rst_data",  32'(out_data),  32'h0);
      checkOutput("t1_rst_addr",  mem_addr,       32'h0);
      checkOutput("t1_rst_busy",  32'(busy),      32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      done_hits = 0;
      repeat (6) begin
         if (done || out_valid) done_hits++;
         @(posedge clk); #1;
      end
      checkOutput("t1_no_done_after_rst", 32'(done_hits), 32'h0);

      // Test 2: one line at 0x40, ready held high (also proves IDLE accepts start).
      applyStimulus(32'h0000_0040, 16'd1);
      runTransfer(1, 200, 1'b0, -1);
      checkWords(32'h0000_0040, 1);
      checkOutput("t2_busy",        32'(busy_at1),      32'd1);
      checkOutput("t2_first_valid", 32'(first_valid),   32'd3);
      checkOutput("t2_last_word",   32'(last_data_acc), 32'd18);
      checkOutput("t2_done_cyc",    32'(done_cyc),      32'(19 + CSUM_ON));
      checkOutput("t2_hold",        32'(hold_err),      32'd0);
      checkOutput("t2_end_addr",    mem_addr,           32'h0000_0060);

      // Test 3: three lines wrapping through address 0.
      applyStimulus(32'hFFFF_FFE0, 16'd3);
      runTransfer(3, 400, 1'b0, -1);
      checkWords(32'hFFFF_FFE0, 3);
      checkOutput("t3_last_word", 32'(last_data_acc), 32'd54);
      checkOutput("t3_end_addr",  mem_addr,           32'h0000_0040);

      // Test 4: ready toggling; 16 words take 32 cycles, stalled words hold.
      applyStimulus(32'h0000_0040, 16'd1);
      runTransfer(1, 400, 1'b1, -1);
      checkWords(32'h0000_0040, 1);
      checkOutput("t4_span", 32'(last_data_acc - first_valid + 1), 32'd32);
      checkOutput("t4_hold", 32'(hold_err), 32'd0);

      // Test 5: zero-line transfer.
      applyStimulus(32'h0000_0200, 16'd0);
      runTransfer(0, 40, 1'b0, -1);
      checkWords(32'h0000_0200, 0);
      checkOutput("t5_done_cyc",    32'(done_cyc),    32'(1 + CSUM_ON));
      checkOutput("t5_first_valid", 32'(first_valid), (CSUM_ON != 0) ? 32'd1 : 32'hFFFF_FFFF);

      // Test 6: start pulsed mid-transfer with base 0x100 is ignored.
      applyStimulus(32'h0000_0085, 16'd1);
      runTransfer(1, 200, 1'b0, 5);
      checkWords(32'h0000_0080, 1);
      checkOutput("t6_end_addr", mem_addr, 32'h0000_00A0);
      repeat (3) begin @(posedge clk); #1; end
      checkOutput("t6_idle_busy",  32'(busy),      32'd0);
      checkOutput("t6_idle_valid", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
